// File: rtl/seq_alu_pkg.sv
// Shared opcodes, FSM encoding and default widths for seq_alu.
package seq_alu_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 16;
  localparam int unsigned DEFAULT_OP_WIDTH   = 4;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_AND   = 4'b0001;
  localparam logic [3:0] OP_OR    = 4'b0010;
  localparam logic [3:0] OP_SLL   = 4'b0011;
  localparam logic [3:0] OP_SRL   = 4'b0100;
  localparam logic [3:0] OP_SRA   = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_EQUAL = 4'b0111;
  localparam logic [3:0] OP_LESS  = 4'b1000;
  localparam logic [3:0] OP_MOVE  = 4'b1001;
  localparam logic [3:0] OP_MUL   = 4'b1010;
  localparam logic [3:0] OP_DIVU  = 4'b1011;
  localparam logic [3:0] OP_REMU  = 4'b1100;
  localparam logic [3:0] OP_EMPTY = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    MD_MUL  = 2'd0,
    MD_DIVU = 2'd1,
    MD_REMU = 2'd2
  } md_mode_e;

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative shift-add multiplier and restoring divider, one step per cycle.
module seq_alu_muldiv
  import seq_alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  md_mode_e              mode_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic                  step_i,
  output logic                  last_c_o,
  output logic [DATA_WIDTH-1:0] result_c_o,
  output logic                  dz_c_o
);

  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned CW = $clog2(DATA_WIDTH);

  md_mode_e        mode_q, mode_d;
  logic [W-1:0]    x_q, x_d;
  logic [W-1:0]    y_q, y_d;
  logic [W-1:0]    acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W:0]      rem_sh;
  logic [W:0]      trial;

  // x: multiplicand (MUL) or dividend shifting into quotient (DIV); y: multiplier or divisor.
  always_comb begin
    mode_d = mode_q;
    x_d    = x_q;
    y_d    = y_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    rem_sh = {acc_q, x_q[W-1]};
    trial  = rem_sh - {1'b0, y_q};
    if (load_i) begin
      mode_d = mode_i;
      x_d    = a_i;
      y_d    = b_i;
      acc_d  = '0;
      cnt_d  = '0;
    end else if (step_i) begin
      cnt_d = last_c_o ? '0 : cnt_q + CW'(1);
      if (mode_q == MD_MUL) begin
        acc_d = acc_q + (y_q[0] ? x_q : '0);
        x_d   = {x_q[W-2:0], 1'b0};
        y_d   = {1'b0, y_q[W-1:1]};
      end else if (!trial[W]) begin
        acc_d = trial[W-1:0];
        x_d   = {x_q[W-2:0], 1'b1};
      end else begin
        acc_d = rem_sh[W-1:0];
        x_d   = {x_q[W-2:0], 1'b0};
      end
    end
  end

  assign last_c_o   = step_i && (cnt_q == CW'(W - 1));
  assign result_c_o = (mode_q == MD_DIVU) ? x_d : acc_d;
  assign dz_c_o     = (mode_q != MD_MUL) && (y_q == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q <= MD_MUL;
      x_q    <= '0;
      y_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
    end else begin
      mode_q <= mode_d;
      x_q    <= x_d;
      y_q    <= y_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arith ops plus optional iterative MUL/DIVU/REMU.
// Define SEQ_ALU_MULDIV_EN to build the iterative multiply/divide datapath.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned OP_WIDTH   = DEFAULT_OP_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [OP_WIDTH-1:0]   op,
  input  logic [DATA_WIDTH-1:0] src_a,
  input  logic [DATA_WIDTH-1:0] src_b,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  div_by_zero
);

  localparam int unsigned W    = DATA_WIDTH;
  localparam int unsigned SH_W = $clog2(DATA_WIDTH);

  state_e       state_q, state_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         dz_q, dz_d;
  logic [W-1:0] result_q, result_d;
  logic [W-1:0] alu_c;
  logic [SH_W-1:0] shamt;
  logic         big_shift;
  logic         md_start_c;
  logic         md_last_c;
  logic         md_dz_c;
  logic [W-1:0] md_result_c;

  assign shamt     = src_b[SH_W-1:0];
  assign big_shift = (src_b >= W'(W));

  // Single-cycle datapath; iterative opcodes fall through to zero here.
  always_comb begin
    alu_c = '0;
    case (op)
      OP_WIDTH'(OP_ADD):   alu_c = src_a + src_b;
      OP_WIDTH'(OP_AND):   alu_c = src_a & src_b;
      OP_WIDTH'(OP_OR):    alu_c = src_a | src_b;
      OP_WIDTH'(OP_SLL):   alu_c = big_shift ? '0 : (src_a << shamt);
      OP_WIDTH'(OP_SRL):   alu_c = big_shift ? '0 : (src_a >> shamt);
      OP_WIDTH'(OP_SRA):   alu_c = big_shift ? {W{src_a[W-1]}} : W'($signed(src_a) >>> shamt);
      OP_WIDTH'(OP_SUB):   alu_c = src_a - src_b;
      OP_WIDTH'(OP_EQUAL): alu_c = {{(W-1){1'b0}}, (src_a != src_b)};
      OP_WIDTH'(OP_LESS):  alu_c = {{(W-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      OP_WIDTH'(OP_MOVE):  alu_c = src_a;
      default:             alu_c = '0;
    endcase
  end

`ifdef SEQ_ALU_MULDIV_EN
  md_mode_e md_mode_c;
  logic     md_load_c;

  always_comb begin
    md_start_c = 1'b1;
    md_mode_c  = MD_MUL;
    case (op)
      OP_WIDTH'(OP_MUL):  md_mode_c = MD_MUL;
      OP_WIDTH'(OP_DIVU): md_mode_c = MD_DIVU;
      OP_WIDTH'(OP_REMU): md_mode_c = MD_REMU;
      default:            md_start_c = 1'b0;
    endcase
  end

  assign md_load_c = start && (state_q != ST_RUN) && md_start_c;

  seq_alu_muldiv #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_muldiv (
    .clk        (clk),
    .rst        (rst),
    .load_i     (md_load_c),
    .mode_i     (md_mode_c),
    .a_i        (src_a),
    .b_i        (src_b),
    .step_i     (state_q == ST_RUN),
    .last_c_o   (md_last_c),
    .result_c_o (md_result_c),
    .dz_c_o     (md_dz_c)
  );
`else
  assign md_start_c  = 1'b0;
  assign md_last_c   = 1'b0;
  assign md_dz_c     = 1'b0;
  assign md_result_c = '0;
`endif

  // FINISH is the done cycle and accepts a new start exactly like IDLE.
  always_comb begin
    state_d  = state_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    dz_d     = dz_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE, ST_FINISH: begin
        state_d = ST_IDLE;
        if (start && md_start_c) begin
          state_d = ST_RUN;
          busy_d  = 1'b1;
        end else if (start) begin
          result_d = alu_c;
          done_d   = 1'b1;
          dz_d     = 1'b0;
        end
      end
      ST_RUN: begin
        busy_d = 1'b1;
        if (md_last_c) begin
          state_d  = ST_FINISH;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          result_d = md_result_c;
          dz_d     = md_dz_c;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
      result_q <= result_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dz_q;
  assign result      = result_q;

endmodule

// File: tb/tb_seq_alu.sv
// Randomized self-checking bench for seq_alu against an arithmetic reference model.
module tb_seq_alu;

  localparam int W = 16;
`ifdef SEQ_ALU_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   op = '0;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_alu #(
    .DATA_WIDTH (W),
    .OP_WIDTH   (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .src_a       (src_a),
    .src_b       (src_b),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .div_by_zero (div_by_zero)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model straight from the opcode table, using wide integer arithmetic.
  function automatic void ref_op(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] r, output logic dz, output bit multi);
    longint unsigned ua = 64'(a);
    longint unsigned ub = 64'(b);
    longint          sa = longint'($signed(a));
    longint          sb = longint'($signed(b));
    r = '0;
    dz = 1'b0;
    multi = 1'b0;
    case (o)
      4'd0:  r = W'(ua + ub);
      4'd1:  r = a & b;
      4'd2:  r = a | b;
      4'd3:  r = (ub >= W) ? '0 : W'(ua << ub);
      4'd4:  r = (ub >= W) ? '0 : W'(ua >> ub);
      4'd5:  r = (ub >= W) ? W'(sa >>> 63) : W'(sa >>> ub);
      4'd6:  r = W'(ua - ub);
      4'd7:  r = (ua == ub) ? W'(0) : W'(1);
      4'd8:  r = (sa < sb) ? W'(1) : W'(0);
      4'd9:  r = a;
      4'd10: if (MD) begin multi = 1'b1; r = W'(ua * ub); end
      4'd11: if (MD) begin multi = 1'b1; dz = (ub == 0); r = (ub == 0) ? '1 : W'(ua / ub); end
      4'd12: if (MD) begin multi = 1'b1; dz = (ub == 0); r = (ub == 0) ? a : W'(ua % ub); end
      default: r = '0;
    endcase
  endfunction

  function automatic logic [W-1:0] rand_b();
    case ($urandom_range(0, 3))
      0:       return '0;
      1:       return W'($urandom_range(0, W + 4));
      2:       return W'($urandom_range(1, 15));
      default: return W'($urandom);
    endcase
  endfunction

  // One isolated operation; poke drives a stray start while busy.
  task automatic run_op(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input bit poke);
    logic [W-1:0] er;
    logic         edz;
    bit           multi;
    ref_op(o, a, b, er, edz, multi);
    op = o; src_a = a; src_b = b; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    if (multi) begin
      for (int c = 1; c <= W; c++) begin
        check_eq("busy_run", {busy, done}, 2'b10);
        if (poke && c == 3) begin
          start = 1'b1; op = 4'd9; src_a = W'($urandom); src_b = W'($urandom);
        end
        @(posedge clk); #1; start = 1'b0;
      end
    end
    check_eq("done_pulse", {busy, done}, 2'b01);
    check_eq("result", result, er);
    check_eq("div_by_zero", div_by_zero, edz);
    @(posedge clk); #1;
    check_eq("done_drop", {busy, done}, 2'b00);
    check_eq("result_hold", result, er);
  endtask

  // Chain of random ops, each new start issued in the done cycle of the previous one.
  task automatic stream(input int n);
    logic [3:0]   o;
    logic [W-1:0] a, b, er;
    logic         edz;
    bit           multi;
    o = 4'($urandom_range(0, 15)); a = W'($urandom); b = rand_b();
    ref_op(o, a, b, er, edz, multi);
    op = o; src_a = a; src_b = b; start = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1; start = 1'b0;
      if (multi) begin
        for (int c = 1; c <= W; c++) begin
          check_eq("stream_busy", {busy, done}, 2'b10);
          @(posedge clk); #1;
        end
      end
      check_eq("stream_done", {busy, done}, 2'b01);
      check_eq("stream_result", result, er);
      check_eq("stream_dz", div_by_zero, edz);
      if (i < n - 1) begin
        o = 4'($urandom_range(0, 15)); a = W'($urandom); b = rand_b();
        ref_op(o, a, b, er, edz, multi);
        op = o; src_a = a; src_b = b; start = 1'b1;
      end
    end
    @(posedge clk); #1;
    check_eq("stream_idle", {busy, done}, 2'b00);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    check_eq("rst_result", result, 16'h0000);
    check_eq("rst_flags", {busy, done, div_by_zero}, 3'b000);
    #10 rst = 1'b1;
    @(posedge clk); #1;

    run_op(4'd0, 16'hFFFF, 16'h0001, 1'b0);
    check_eq("add_wrap", result, 16'h0000);
    run_op(4'd5, 16'h8000, 16'd3, 1'b0);
    check_eq("sra_3", result, 16'hF000);
    run_op(4'd5, 16'h8000, 16'd20, 1'b0);
    check_eq("sra_20", result, 16'hFFFF);
    run_op(4'd3, 16'h0001, 16'd16, 1'b0);
    check_eq("sll_16", result, 16'h0000);
    run_op(4'd7, 16'h1234, 16'h1234, 1'b0);
    check_eq("equal_same", result, 16'h0000);
    run_op(4'd8, 16'hFFFF, 16'h0001, 1'b0);
    check_eq("less_signed", result, 16'h0001);

    run_op(4'd10, 16'h0123, 16'h0010, 1'b1);
`ifdef SEQ_ALU_MULDIV_EN
    check_eq("mul_const", result, 16'h1230);
    run_op(4'd11, 16'd100, 16'd7, 1'b1);
    check_eq("divu_const", result, 16'd14);
    run_op(4'd12, 16'd100, 16'd7, 1'b0);
    check_eq("remu_const", result, 16'd2);
    run_op(4'd11, 16'd5, 16'd0, 1'b0);
    check_eq("div0_const", {div_by_zero, result}, {1'b1, 16'hFFFF});
`else
    check_eq("mul_disabled", result, 16'h0000);
    run_op(4'd10, 16'd3, 16'd4, 1'b0);
    check_eq("mul_3x4_disabled", result, 16'h0000);
    run_op(4'd11, 16'd5, 16'd0, 1'b0);
    check_eq("div0_disabled", {div_by_zero, result}, {1'b0, 16'h0000});
`endif

    // Abort a DIVU by reset in its fifth cycle.
    run_op(4'd9, 16'hBEEF, 16'h0000, 1'b0);
    op = 4'd11; src_a = 16'd1000; src_b = 16'd7; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    #1 rst = 1'b0;
    #1;
    check_eq("abort_result", result, 16'h0000);
    check_eq("abort_flags", {busy, done, div_by_zero}, 3'b000);
    @(negedge clk); rst = 1'b1;
    for (int c = 0; c < W + 3; c++) begin
      @(posedge clk); #1;
      check_eq("abort_quiet", {busy, done}, 2'b00);
    end
    run_op(4'd0, 16'd2, 16'd3, 1'b0);
    check_eq("add_after_rst", result, 16'd5);

    for (int i = 0; i < 40; i++)
      run_op(4'($urandom_range(0, 15)), W'($urandom), rand_b(), 1'($urandom_range(0, 1)));
    stream(120);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001: Parameter DATA_WIDTH, default 16, operand and result width in bits; legal values 8 to 32.
REQ-002: Parameter OP_WIDTH, default 4, opcode width in bits.
REQ-003: Port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004: Port rst, input, 1 bit, reset; asynchronous, active-low.
REQ-005: Port start, input, 1 bit, request to begin an operation; sampled only while busy=0.
REQ-006: Port op, input, OP_WIDTH bits, opcode; captured with start.
REQ-007: Port src_a, input, DATA_WIDTH bits, operand A; captured with start.
REQ-008: Port src_b, input, DATA_WIDTH bits, operand B; captured with start.
REQ-009: Port busy, output, 1 bit, high while a multi-cycle operation runs.
REQ-010: Port done, output, 1 bit, one-cycle pulse marking a new valid result.
REQ-011: Port result, output, DATA_WIDTH bits, registered result; held until the next done.
REQ-012: Port div_by_zero, output, 1 bit, set with done for DIVU/REMU with src_b=0, else cleared with done.

Function
REQ-013: Opcodes: ADD=0000, AND=0001, OR=0010, SLL=0011, SRL=0100, SRA=0101, SUB=0110, EQUAL=0111, LESS=1000, MOVE=1001, MUL=1010, DIVU=1011, REMU=1100, EMPTY=1111; every other code yields 0.
REQ-014: ADD/SUB wrap modulo 2^DATA_WIDTH; AND/OR bitwise; MOVE returns src_a.
REQ-015: Shifts use the full unsigned src_b; amount >= DATA_WIDTH gives 0 for SLL/SRL and all copies of src_a MSB for SRA.
REQ-016: EQUAL returns 0 when src_a==src_b, else 1; LESS returns 1 when signed src_a < signed src_b, else 0.
REQ-017: Single-cycle ops: start accepted at edge k gives result and done=1 in the cycle after edge k; busy stays 0.
REQ-018: MUL returns the low DATA_WIDTH bits of the unsigned product, one shift-add step per cycle.
REQ-019: DIVU returns the unsigned quotient and REMU the remainder, one restoring-division step per cycle.
REQ-020: A multi-cycle op accepted at edge k drives busy=1 from edge k through edge k+DATA_WIDTH, and done=1 in the cycle after edge k+DATA_WIDTH.
REQ-021: A divisor of 0 gives quotient all-ones, remainder = src_a, div_by_zero=1, with the same latency as a nonzero divisor.
REQ-022: start while busy=1 is ignored and does not change the captured operands.
REQ-023: start in the same cycle as done is accepted; back-to-back single-cycle ops sustain one result per cycle.
REQ-024: FSM states: IDLE (accept start), RUN (iterate, counter 0..DATA_WIDTH-1), FINISH (write result, pulse done, return to IDLE).
REQ-025: done is high for exactly one cycle per accepted operation.

Reset
REQ-026: Asserting rst forces result=0, busy=0, done=0, div_by_zero=0, FSM=IDLE, iteration counter=0.
REQ-027: rst asserted mid-operation aborts the operation with no done pulse; the first start after release is accepted normally.

Configuration
REQ-028: Macro SEQ_ALU_MULDIV_EN defined: MUL, DIVU and REMU are implemented as specified.
REQ-029: Macro SEQ_ALU_MULDIV_EN undefined: MUL/DIVU/REMU behave as unknown opcodes (result 0, single-cycle, busy never asserted, div_by_zero always 0); no iterative datapath is synthesised.

Structure
REQ-030: Shared package seq_alu_pkg holds the opcode constants, the FSM state encoding and the default DATA_WIDTH.
REQ-031: The iterative multiply/divide datapath lives in sub-module seq_alu_muldiv (operand, accumulator and counter registers), instantiated only under SEQ_ALU_MULDIV_EN.

Verification
REQ-032: ADD 0xFFFF+0x0001 (W=16) -> result 0x0000, done one cycle after start, busy stays 0.
REQ-033: SRA 0x8000 by 3 -> 0xF000; SRA 0x8000 by 20 -> 0xFFFF; SLL 0x0001 by 16 -> 0x0000.
REQ-034: MUL 0x0123*0x0010 -> 0x1230, busy high 16 cycles, done on cycle 17; a start during busy is ignored.
REQ-035: DIVU 100/7 -> 14 and REMU 100/7 -> 2; DIVU 5/0 -> 0xFFFF with div_by_zero=1.
REQ-036: rst pulsed on cycle 5 of a DIVU -> outputs zero immediately, no done; next ADD 2+3 -> 5.
REQ-037: With SEQ_ALU_MULDIV_EN undefined, MUL 3*4 -> 0 after one cycle, busy never asserted.
